// File: rtl/multu_seq.sv
// Sequential 32x32 unsigned shift-add multiplier for MULTU in EX.
// One partial product per cycle; done strobes for one cycle when dataOut is loaded.
module multu_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH:0]   r_prod;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_dout;

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_prod_nxt;

    // Upper half plus multiplicand keeps its carry; the whole thing shifts right
    // so the carry lands in bit 2*WIDTH-1 and the consumed multiplier bit drops out.
    always_comb begin
        w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]};
        if (r_prod[0])
            w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        w_prod_nxt = {1'b0, w_sum, r_prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= dataA;
                        r_prod  <= {1'b0, {WIDTH{1'b0}}, dataB};
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_prod <= w_prod_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_dout  <= w_prod_nxt[2*WIDTH-1:0];
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign dataOut = r_dout;
endmodule

// File: tb/tb_multu_seq.sv
// Bench for multu_seq: cycle-level reference model plus directed literal checks and random multiplies.
module tb_multu_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic        busy;
    logic        done;
    logic [63:0] dataOut;

    multu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .dataA(dataA), .dataB(dataB),
        .busy(busy), .done(done), .dataOut(dataOut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Reference model: m_t counts cycles since the accepted start edge (0 = idle).
    // Cycle 33 is the done cycle, when the product becomes visible.
    int          m_t   = 0;
    logic [63:0] m_res = '0;
    logic [63:0] m_out = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_t   = 0;
            m_out = '0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t   = 1;
                m_res = 64'(dataA) * 64'(dataB);
            end
        end else if (m_t == 33) begin
            m_t = 0;
        end else begin
            m_t++;
            if (m_t == 33) m_out = m_res;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_busy", 64'(busy), 64'(m_t != 0));
            chk("mdl_done", 64'(done), 64'(m_t == 33));
            chk("mdl_dataOut", dataOut, m_out);
        end
    end

    logic [63:0] last_exp = '0;

    // Pulses start with a,b, scrambles operands after the start edge, optionally
    // fires an ignored start at cycle 'bump', and returns in the first IDLE cycle.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] req, input int bump);
        int lat = -1;
        int nb  = 0;
        dataA = a; dataB = b; start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = (i == bump);
            if (i == bump) begin
                dataA = 32'd100; dataB = 32'd100;
            end else begin
                dataA = $urandom; dataB = $urandom;
            end
            if (busy) nb++;
            if (i == 16) chk("held_mid_run", dataOut, last_exp);
            if (done) begin
                lat = i;
                chk("product", dataOut, req);
                break;
            end
        end
        // Done is seen at the 33rd falling edge after driving start: 32 cycles after the start edge.
        chk("latency", 64'(lat), 64'd33);
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_done", 64'(busy), 64'd0);
        chk("busy_cycles", 64'(nb), 64'd33);
        last_exp = req;
    endtask

    initial begin
        int nd;
        logic [31:0] ra, rb;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dataOut", dataOut, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_mul(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
        run_mul(32'd0, 32'h1234_5678, 64'd0, 0);
        run_mul(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 0);

        // Start while busy is ignored; only one done follows.
        run_mul(32'd7, 32'd9, 64'd63, 5);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_second_done", 64'(nd), 64'd0);

        // Reset mid-operation discards the partial result.
        dataA = 32'hDEAD_BEEF; dataB = 32'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_dataOut", dataOut, 64'd0);
        last_exp = '0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("rst_no_done", 64'(nd), 64'd0);
        run_mul(32'd6, 32'd7, 64'd42, 0);

        // Back-to-back: second start in the first IDLE cycle after done.
        run_mul(32'd2, 32'd3, 64'd6, 0);
        run_mul(32'd4, 32'd5, 64'd20, 0);

        for (int k = 0; k < 20; k++) begin
            ra = $urandom;
            rb = (k % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_mul(ra, rb, 64'(ra) * 64'(rb), (k % 3 == 0) ? int'($urandom_range(2, 33)) : 0);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
